// File: rtl/rhd_pkg.sv
// Shared constants and command-word helpers for the RHD command sequencer.
// Command word layout: [15:14] opcode, [13:8] register/channel, [7:0] data.
package rhd_pkg;

    localparam int NUM_CONV    = 32;
    localparam int NUM_PAD     = 2;
    localparam int NUM_AUX     = 6;
    localparam int FRAME_SLOTS = NUM_CONV + NUM_PAD + NUM_AUX;
    localparam int CFG_LEN     = 18;
    localparam int CAL_DUMMIES = 9;

    localparam logic [1:0] OP_CONVERT   = 2'b00;
    localparam logic [1:0] OP_CALIBRATE = 2'b01;
    localparam logic [1:0] OP_WRITE     = 2'b10;
    localparam logic [1:0] OP_READ      = 2'b11;

    localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
    localparam logic [5:0]  PAD_REG       = 6'd40;

    // Slot landmarks, kept 6 bits wide to match the slot counter.
    localparam logic [5:0] SLOT_CFG_LAST = 6'(CFG_LEN - 1);
    localparam logic [5:0] SLOT_CAL      = 6'(CFG_LEN);
    localparam logic [5:0] SLOT_CAL_LAST = 6'(CFG_LEN + CAL_DUMMIES);
    localparam logic [5:0] SLOT_PAD0     = 6'(NUM_CONV);
    localparam logic [5:0] SLOT_AUX0     = 6'(NUM_CONV + NUM_PAD);
    localparam logic [5:0] SLOT_LAST     = 6'(FRAME_SLOTS - 1);

    localparam logic [7:0] CFG_ROM [CFG_LEN] = '{
        8'hDE, 8'h20, 8'h28, 8'h02, 8'h9C, 8'h00, 8'h00, 8'h00, 8'h16,
        8'h17, 8'hA8, 8'h0A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
    };

    localparam logic [5:0] AUX_REGS [NUM_AUX] = '{
        6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd63
    };

    typedef enum logic {
        MODE_CFG = 1'b0,
        MODE_REC = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG  = 3'd1,
        ST_CAL  = 3'd2,
        ST_REC  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic [15:0] mk_write(input logic [5:0] r, input logic [7:0] d);
        return {OP_WRITE, r, d};
    endfunction

    function automatic logic [15:0] mk_read(input logic [5:0] r);
        return {OP_READ, r, 8'h00};
    endfunction

    function automatic logic [15:0] mk_convert(input logic [5:0] c);
        return {OP_CONVERT, c, 8'h00};
    endfunction

endpackage

// File: rtl/rhd_slot_encoder.sv
// Combinational map from (mode, slot) to the 16-bit RHD command word.
module rhd_slot_encoder
    import rhd_pkg::*;
(
    input  mode_e       mode_i,
    input  logic [5:0]  slot_i,
    output logic [15:0] cmd_o
);

    logic [5:0] aux_off;

    always_comb begin
        aux_off = slot_i - SLOT_AUX0;
        // Dummy READ(40) covers the calibrate tail and the pipeline pads.
        cmd_o   = mk_read(PAD_REG);
        if (mode_i == MODE_CFG) begin
            if (slot_i <= SLOT_CFG_LAST) begin
                cmd_o = mk_write(slot_i, CFG_ROM[slot_i[4:0]]);
            end else if (slot_i == SLOT_CAL) begin
                cmd_o = CMD_CALIBRATE;
            end
        end else begin
            if (slot_i < SLOT_PAD0) begin
                cmd_o = mk_convert(slot_i);
            end else if (slot_i >= SLOT_AUX0) begin
                cmd_o = mk_read(AUX_REGS[aux_off[2:0]]);
            end
        end
    end

endmodule

// File: rtl/rhd_cmd_sequencer.sv
// Command sequencer feeding the RHD SPI master: config list + calibrate, or looping record frames.
// Handshake: a word moves on a clk edge with cmd_valid && cmd_ready; until then the word and its tags hold.
module rhd_cmd_sequencer
    import rhd_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        config_start,
    input  logic        record_start,
    input  logic        record_stop,
    output logic [15:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [5:0]  cmd_slot,
    output logic        frame_start,
    output logic        frame_end,
    output logic        busy,
    output logic        done,
    output logic [31:0] frame_count
);

    state_e      state_q, state_d;
    logic [5:0]  slot_q, slot_d;
    logic        stop_q, stop_d;
    logic [31:0] fcnt_q, fcnt_d;
    logic        xfer;
    logic        stop_now;
    mode_e       mode;
    logic [15:0] enc_word;

    rhd_slot_encoder u_enc (
        .mode_i (mode),
        .slot_i (slot_q),
        .cmd_o  (enc_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            stop_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            stop_q  <= stop_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        stop_d   = stop_q;
        fcnt_d   = fcnt_q;
        xfer     = cmd_valid && cmd_ready;
        // A stop arriving on the slot-39 transfer still makes this frame the last.
        stop_now = stop_q || record_stop;
        case (state_q)
            ST_IDLE: begin
                slot_d = '0;
                if (config_start) begin
                    state_d = ST_CFG;
                end else if (record_start) begin
                    state_d = ST_REC;
                    fcnt_d  = '0;
                    stop_d  = 1'b0;
                end
            end
            ST_CFG: begin
                if (xfer) begin
                    slot_d = slot_q + 6'd1;
                    if (slot_q == SLOT_CFG_LAST) begin
                        state_d = ST_CAL;
                    end
                end
            end
            ST_CAL: begin
                if (xfer) begin
                    if (slot_q == SLOT_CAL_LAST) begin
                        state_d = ST_DONE;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + 6'd1;
                    end
                end
            end
            ST_REC: begin
                stop_d = stop_now;
                if (xfer) begin
                    if (slot_q == SLOT_LAST) begin
                        slot_d = '0;
                        fcnt_d = fcnt_q + 32'd1;
                        if (stop_now) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        slot_d = slot_q + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase
    end

    always_comb begin
        mode        = (state_q == ST_REC) ? MODE_REC : MODE_CFG;
        cmd_valid   = (state_q == ST_CFG) || (state_q == ST_CAL) || (state_q == ST_REC);
        busy        = cmd_valid;
        done        = (state_q == ST_DONE);
        cmd_data    = cmd_valid ? enc_word : 16'h0000;
        cmd_slot    = slot_q;
        frame_start = (state_q == ST_REC) && (slot_q == 6'd0);
        frame_end   = (state_q == ST_REC) && (slot_q == SLOT_LAST);
        frame_count = fcnt_q;
    end

endmodule

// File: tb/tb_rhd_cmd_sequencer.sv
// Scoreboarded bench for rhd_cmd_sequencer with a slot-level reference model.
module tb_rhd_cmd_sequencer;

    localparam int W = 25; // {last, frame_start, frame_end, slot[5:0], data[15:0]}

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        config_start = 1'b0;
    logic        record_start = 1'b0;
    logic        record_stop = 1'b0;
    logic        cmd_ready = 1'b0;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic [5:0]  cmd_slot;
    logic        frame_start;
    logic        frame_end;
    logic        busy;
    logic        done;
    logic [31:0] frame_count;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    bit rand_ready = 1'b0;
    bit hold_ready = 1'b0;

    logic [W-1:0] exp_q[$];

    logic [7:0] ref_rom [18] = '{
        8'hDE, 8'h20, 8'h28, 8'h02, 8'h9C, 8'h00, 8'h00, 8'h00, 8'h16,
        8'h17, 8'hA8, 8'h0A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
    };
    int ref_aux [6] = '{40, 41, 42, 43, 44, 63};

    rhd_cmd_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .config_start (config_start),
        .record_start (record_start),
        .record_stop  (record_stop),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_slot     (cmd_slot),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .busy         (busy),
        .done         (done),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: config sequence is 18 writes, calibrate, 9 READ(40).
    task automatic push_config();
        logic [15:0] w;
        for (int k = 0; k < 28; k++) begin
            if (k < 18)       w = 16'h8000 | 16'(k * 256) | {8'h00, ref_rom[k]};
            else if (k == 18) w = 16'h5500;
            else              w = 16'hE800;
            exp_q.push_back({(k == 27), 1'b0, 1'b0, 6'(k), w});
        end
    endtask

    // Record frame: 32 converts, 2 pads, then reads of the aux register list.
    task automatic push_frames(input int n);
        logic [15:0] w;
        for (int f = 0; f < n; f++) begin
            for (int s = 0; s < 40; s++) begin
                if (s < 32)      w = 16'(s * 256);
                else if (s < 34) w = 16'hC000 | 16'(40 * 256);
                else             w = 16'hC000 | 16'(ref_aux[s - 34] * 256);
                exp_q.push_back({(f == n - 1 && s == 39), (s == 0), (s == 39), 6'(s), w});
            end
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [23:0] got;
        logic [23:0] prev_word;
        logic [W-1:0] e;
        bit prev_stall;
        bit prev_mid;
        bit exp_done;
        prev_word  = '0;
        prev_stall = 1'b0;
        prev_mid   = 1'b0;
        exp_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_stall = 1'b0;
                prev_mid   = 1'b0;
                exp_done   = 1'b0;
                continue;
            end
            got = {frame_start, frame_end, cmd_slot, cmd_data};
            if (done) done_cnt++;
            if (exp_done) begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_at_done", 32'(busy), 32'd0);
                exp_done = 1'b0;
            end else if (done) begin
                check("done_unexpected", 32'(done), 32'd0);
            end
            if (prev_stall) check("hold_stable", 32'(got), 32'(prev_word));
            if (prev_mid) check("zero_bubble_valid", 32'(cmd_valid), 32'd1);
            if (cmd_valid) check("busy_with_valid", 32'(busy), 32'd1);
            prev_stall = cmd_valid && !cmd_ready;
            prev_word  = got;
            prev_mid   = 1'b0;
            if (cmd_valid && cmd_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 32'(got), 32'(e[23:0]));
                    exp_done = e[24];
                    prev_mid = !e[24];
                end
            end
        end
    end

    // Ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!hold_ready) cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic pulse_start(input bit cfg, input bit rec);
        @(posedge clk); #1;
        config_start = cfg;
        record_start = rec;
        @(posedge clk); #1;
        config_start = 1'b0;
        record_start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1;
        record_stop = 1'b1;
        @(posedge clk); #1;
        record_stop = 1'b0;
    endtask

    task automatic wait_xfers(input int base, input int n);
        int t = 0;
        while ((xfer_cnt - base) < n && t < 5000) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= 5000) check("xfer_timeout", 32'(xfer_cnt - base), 32'(n));
    endtask

    task automatic wait_done(input int old);
        int t = 0;
        while (done_cnt <= old && t < 5000) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= 5000) check("done_timeout", 32'(done_cnt), 32'(old + 1));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic record_run(input int n, input int k, input bit rnd);
        int base;
        int d0;
        rand_ready = rnd;
        push_frames(n);
        base = xfer_cnt;
        d0 = done_cnt;
        pulse_start(1'b0, 1'b1);
        wait_xfers(base, (n - 1) * 40 + k);
        pulse_stop();
        wait_done(d0);
        check("frame_count", frame_count, 32'(n));
    endtask

    initial begin
        int base;
        int d0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cmd_data", 32'(cmd_data), 32'd0);
        check("rst_cmd_slot", 32'(cmd_slot), 32'd0);
        check("rst_markers", 32'({frame_start, frame_end}), 32'd0);
        check("rst_frame_count", frame_count, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Config run at full rate
        push_config();
        d0 = done_cnt;
        pulse_start(1'b1, 1'b0);
        wait_done(d0);

        // Single frame, stop mid-frame, full rate
        record_run(1, 15, 1'b0);

        // Backpressure at slot 10
        rand_ready = 1'b0;
        push_frames(1);
        base = xfer_cnt;
        d0 = done_cnt;
        pulse_start(1'b0, 1'b1);
        wait_xfers(base, 10);
        @(posedge clk); #1;
        hold_ready = 1'b1;
        cmd_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_data", 32'(cmd_data), 32'h0A00);
            check("bp_slot", 32'(cmd_slot), 32'd10);
            @(posedge clk); #1;
        end
        cmd_ready = 1'b1;
        hold_ready = 1'b0;
        wait_xfers(base, 20);
        pulse_stop();
        wait_done(d0);
        check("bp_frame_count", frame_count, 32'd1);

        // Stop on the slot-39 transfer cycle of frame 2
        record_run(2, 39, 1'b0);

        // Randomized multi-frame runs
        for (int i = 0; i < 3; i++) begin
            record_run(int'($urandom_range(1, 3)), int'($urandom_range(0, 39)), 1'b1);
        end
        record_run(2, 39, 1'b1);

        // Simultaneous starts: config wins; a record_start while busy is ignored
        base = int'(frame_count);
        rand_ready = 1'b1;
        push_config();
        d0 = done_cnt;
        pulse_start(1'b1, 1'b1);
        wait_xfers(xfer_cnt, 5);
        pulse_start(1'b0, 1'b1);
        wait_done(d0);
        check("cfg_keeps_frame_count", frame_count, 32'(base));

        // Asynchronous reset at frame 2 slot 20
        rand_ready = 1'b0;
        push_frames(3);
        base = xfer_cnt;
        pulse_start(1'b0, 1'b1);
        wait_xfers(base, 60);
        @(posedge clk); #1;
        check("pre_rst_frame_count", frame_count, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_frame_count", frame_count, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle_valid", 32'(cmd_valid), 32'd0);
        check("post_rst_idle_busy", 32'(busy), 32'd0);

        // Config again under random backpressure
        rand_ready = 1'b1;
        push_config();
        d0 = done_cnt;
        pulse_start(1'b1, 1'b0);
        wait_done(d0);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
